// File: rtl/rvfi_mon_pkg.sv
// Shared RVFI packet type and sizing helpers for the commit-ordering buffer.
package rvfi_mon_pkg;

  typedef struct packed {
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_rdata;
    logic [31:0] rs2_rdata;
    logic        load_regfile;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
    logic [31:0] pc_wdata;
    logic [31:0] mem_addr;
    logic [3:0]  mem_rmask;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata;
    logic [31:0] mem_wdata;
    logic        trap;
  } rvfi_pkt_t;

  function automatic int tag_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/rvfi_commit_rob.sv
// Commit-ordering buffer: accepts out-of-order completions and retires at most
// one RVFI packet per cycle in dispatch order, tracking order, halt and errors.
module rvfi_commit_rob
  import rvfi_mon_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int NUM_WB  = 2,
  parameter int ORDER_W = 64,
  localparam int TAG_W  = tag_w(DEPTH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         alloc_valid,
  input  logic [31:0]                  alloc_pc,
  input  logic [31:0]                  alloc_inst,
  output logic                         alloc_ready,
  output logic [TAG_W-1:0]             alloc_tag,
  input  logic [NUM_WB-1:0]            wb_valid,
  input  logic [NUM_WB-1:0][TAG_W-1:0] wb_tag,
  input  rvfi_pkt_t [NUM_WB-1:0]       wb_pkt,
  input  logic                         flush,
  output logic                         commit,
  output logic [ORDER_W-1:0]           commit_order,
  output logic [31:0]                  commit_pc,
  output logic [31:0]                  commit_inst,
  output rvfi_pkt_t                    commit_pkt,
  output logic                         halt,
  output logic                         wb_err
);

  localparam logic [TAG_W:0] FULL_CNT = (TAG_W+1)'(DEPTH);

  logic             valid_q [DEPTH];
  logic             done_q  [DEPTH];
  logic [31:0]      pc_q    [DEPTH];
  logic [31:0]      inst_q  [DEPTH];
  rvfi_pkt_t        pkt_q   [DEPTH];

  logic [TAG_W-1:0]   head_q;
  logic [TAG_W-1:0]   tail_q;
  logic [TAG_W:0]     count_q;
  logic [ORDER_W-1:0] order_cnt_q;

  logic [NUM_WB-1:0] wb_win;
  logic [NUM_WB-1:0] wb_bad;
  logic              dup;
  logic              retire;
  logic              alloc_fire;
  logic              wb_err_set;
  logic [TAG_W-1:0]  head_next;
  logic [TAG_W:0]    count_next;

  // Alloc handshake: an entry is granted on a clock edge where alloc_valid and
  // alloc_ready are both high; alloc_ready depends only on occupancy, and
  // alloc_tag names the entry that edge will grant.
  assign alloc_ready = (count_q != FULL_CNT);
  assign alloc_tag   = tail_q;

  assign retire     = valid_q[head_q] && done_q[head_q] && !halt;
  assign alloc_fire = alloc_valid && alloc_ready && !flush;
  assign head_next  = head_q + TAG_W'(retire);
  assign count_next = count_q + (TAG_W+1)'(alloc_fire) - (TAG_W+1)'(retire);
  assign wb_err_set = (|wb_bad) && !flush;

  // Lower channel index wins when two completions target the same tag.
  always_comb begin
    wb_win = '0;
    wb_bad = '0;
    dup    = 1'b0;
    for (int i = 0; i < NUM_WB; i++) begin
      dup = 1'b0;
      for (int j = 0; j < i; j++) begin
        if (wb_valid[j] && (wb_tag[j] == wb_tag[i])) dup = 1'b1;
      end
      if (wb_valid[i]) begin
        if (!valid_q[wb_tag[i]] || done_q[wb_tag[i]] || dup) wb_bad[i] = 1'b1;
        else                                                   wb_win[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        valid_q[k] <= 1'b0;
        done_q[k]  <= 1'b0;
        pc_q[k]    <= '0;
        inst_q[k]  <= '0;
        pkt_q[k]   <= '0;
      end
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      order_cnt_q  <= '0;
      commit       <= 1'b0;
      commit_order <= '0;
      commit_pc    <= '0;
      commit_inst  <= '0;
      commit_pkt   <= '0;
      halt         <= 1'b0;
      wb_err       <= 1'b0;
    end else begin
      commit <= retire;
      if (retire) begin
        commit_pc       <= pc_q[head_q];
        commit_inst     <= inst_q[head_q];
        commit_pkt      <= pkt_q[head_q];
        commit_order    <= order_cnt_q;
        order_cnt_q     <= order_cnt_q + 1'b1;
        valid_q[head_q] <= 1'b0;
        if (pkt_q[head_q].pc_wdata == pc_q[head_q]) halt <= 1'b1;
      end

      if (!flush) begin
        for (int i = 0; i < NUM_WB; i++) begin
          if (wb_win[i]) begin
            pkt_q[wb_tag[i]]  <= wb_pkt[i];
            done_q[wb_tag[i]] <= 1'b1;
          end
        end
      end
      if (wb_err_set) wb_err <= 1'b1;

      if (alloc_fire) begin
        valid_q[tail_q] <= 1'b1;
        done_q[tail_q]  <= 1'b0;
        pc_q[tail_q]    <= alloc_pc;
        inst_q[tail_q]  <= alloc_inst;
        pkt_q[tail_q]   <= '0;
        tail_q          <= tail_q + 1'b1;
      end

      head_q <= head_next;

      // Flush keeps the retire decided above, then squashes everything younger.
      if (flush) begin
        for (int k = 0; k < DEPTH; k++) begin
          valid_q[k] <= 1'b0;
          done_q[k]  <= 1'b0;
        end
        tail_q  <= head_next;
        count_q <= '0;
      end else begin
        count_q <= count_next;
      end
    end
  end

endmodule

// File: tb/tb_rvfi_commit_rob.sv
// Directed bench for rvfi_commit_rob: vector table plus multi-cycle corner sequences.
module tb_rvfi_commit_rob;
  import rvfi_mon_pkg::*;

  logic                  clk;
  logic                  rst;
  logic                  alloc_valid;
  logic [31:0]           alloc_pc;
  logic [31:0]           alloc_inst;
  logic                  alloc_ready;
  logic [2:0]            alloc_tag;
  logic [1:0]            wb_valid;
  logic [1:0][2:0]       wb_tag;
  rvfi_pkt_t [1:0]       wb_pkt;
  logic                  flush;
  logic                  commit;
  logic [63:0]           commit_order;
  logic [31:0]           commit_pc;
  logic [31:0]           commit_inst;
  rvfi_pkt_t             commit_pkt;
  logic                  halt;
  logic                  wb_err;

  int checks   = 0;
  int failures = 0;
  logic        mon_en = 1'b0;
  logic [95:0] exp_q[$];

  rvfi_commit_rob #(.DEPTH(8), .NUM_WB(2), .ORDER_W(64)) dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_pc(alloc_pc), .alloc_inst(alloc_inst),
    .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_pkt(wb_pkt),
    .flush(flush),
    .commit(commit), .commit_order(commit_order), .commit_pc(commit_pc),
    .commit_inst(commit_inst), .commit_pkt(commit_pkt),
    .halt(halt), .wb_err(wb_err)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic        rst;
    logic        av;
    logic [31:0] apc;
    logic        wv;
    logic [2:0]  t0;
    logic [31:0] rd0;
    logic        e_commit;
    logic [63:0] e_order;
    logic [31:0] e_pc;
    logic [31:0] e_rd;
    logic [2:0]  e_tag;
    logic        e_ready;
    logic        e_err;
  } vec_t;

  vec_t tbl[21];

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return {pc[15:0], pc[15:0]};
  endfunction

  function automatic rvfi_pkt_t mk_pkt(input logic [31:0] rd, input logic [31:0] pcw);
    rvfi_pkt_t p;
    p = '0;
    p.rd_wdata     = rd;
    p.pc_wdata     = pcw;
    p.load_regfile = 1'b1;
    p.rd_addr      = rd[4:0];
    return p;
  endfunction

  function automatic vec_t mkv(input logic r, input logic av, input logic [31:0] apc,
                               input logic wv, input logic [2:0] t0, input logic [31:0] rd0,
                               input logic ec, input logic [63:0] eo, input logic [31:0] epc,
                               input logic [31:0] erd, input logic [2:0] etag);
    vec_t v;
    v.rst = r; v.av = av; v.apc = apc; v.wv = wv; v.t0 = t0; v.rd0 = rd0;
    v.e_commit = ec; v.e_order = eo; v.e_pc = epc; v.e_rd = erd; v.e_tag = etag;
    v.e_ready = 1'b1; v.e_err = 1'b0;
    return v;
  endfunction

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    rst         = 1'b0;
    alloc_valid = 1'b0;
    alloc_pc    = '0;
    alloc_inst  = '0;
    wb_valid    = '0;
    wb_tag      = '0;
    wb_pkt      = '0;
    flush       = 1'b0;
  endtask

  task automatic do_reset();
    idle_in();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic do_alloc(input logic [31:0] pc);
    alloc_valid = 1'b1;
    alloc_pc    = pc;
    alloc_inst  = inst_of(pc);
    tick();
    alloc_valid = 1'b0;
  endtask

  task automatic set_wb(input logic [1:0] v, input logic [2:0] t0, input logic [31:0] rd0,
                        input logic [31:0] pcw0, input logic [2:0] t1, input logic [31:0] rd1,
                        input logic [31:0] pcw1);
    wb_valid  = v;
    wb_tag[0] = t0;
    wb_tag[1] = t1;
    wb_pkt[0] = mk_pkt(rd0, pcw0);
    wb_pkt[1] = mk_pkt(rd1, pcw1);
  endtask

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic wait_commit(input logic [31:0] pc, input int max, input string name);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < max && !seen; k++) begin
      tick();
      if (commit && commit_pc == pc) seen = 1'b1;
    end
    chk(name, 96'(seen), 96'(1));
  endtask

  // Scoreboard: in-order commit stream against {order, pc} expectations
  always @(negedge clk) begin
    if (mon_en && commit) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL mon_extra act=pc%0h exp=none", commit_pc);
      end else begin
        chk("mon_commit", {commit_order, commit_pc}, exp_q.pop_front());
      end
    end
  end

  initial begin
    localparam logic [31:0] NOPC = 32'hFFFF_FFF0;

    // In-order: four allocs, completions in tag order
    tbl[0]  = mkv(0, 1, 32'h60,  0, 0, 0,          0, 0, 32'h0,   32'h0,    1);
    tbl[1]  = mkv(0, 1, 32'h64,  0, 0, 0,          0, 0, 32'h0,   32'h0,    2);
    tbl[2]  = mkv(0, 1, 32'h68,  0, 0, 0,          0, 0, 32'h0,   32'h0,    3);
    tbl[3]  = mkv(0, 1, 32'h6C,  0, 0, 0,          0, 0, 32'h0,   32'h0,    4);
    tbl[4]  = mkv(0, 0, 32'h0,   1, 0, 32'h1000,   0, 0, 32'h0,   32'h0,    4);
    tbl[5]  = mkv(0, 0, 32'h0,   1, 1, 32'h1001,   1, 0, 32'h60,  32'h1000, 4);
    tbl[6]  = mkv(0, 0, 32'h0,   1, 2, 32'h1002,   1, 1, 32'h64,  32'h1001, 4);
    tbl[7]  = mkv(0, 0, 32'h0,   1, 3, 32'h1003,   1, 2, 32'h68,  32'h1002, 4);
    tbl[8]  = mkv(0, 0, 32'h0,   0, 0, 0,          1, 3, 32'h6C,  32'h1003, 4);
    tbl[9]  = mkv(0, 0, 32'h0,   0, 0, 0,          0, 3, 32'h6C,  32'h1003, 4);
    // Mid-run reset, then out-of-order completion of tags 2,1,0
    tbl[10] = mkv(1, 0, 32'h0,   0, 0, 0,          0, 0, 32'h0,   32'h0,    0);
    tbl[11] = mkv(0, 1, 32'h100, 0, 0, 0,          0, 0, 32'h0,   32'h0,    1);
    tbl[12] = mkv(0, 1, 32'h104, 0, 0, 0,          0, 0, 32'h0,   32'h0,    2);
    tbl[13] = mkv(0, 1, 32'h108, 0, 0, 0,          0, 0, 32'h0,   32'h0,    3);
    tbl[14] = mkv(0, 0, 32'h0,   1, 2, 32'h2002,   0, 0, 32'h0,   32'h0,    3);
    tbl[15] = mkv(0, 0, 32'h0,   1, 1, 32'h2001,   0, 0, 32'h0,   32'h0,    3);
    tbl[16] = mkv(0, 0, 32'h0,   1, 0, 32'h2000,   0, 0, 32'h0,   32'h0,    3);
    tbl[17] = mkv(0, 0, 32'h0,   0, 0, 0,          1, 0, 32'h100, 32'h2000, 3);
    tbl[18] = mkv(0, 0, 32'h0,   0, 0, 0,          1, 1, 32'h104, 32'h2001, 3);
    tbl[19] = mkv(0, 0, 32'h0,   0, 0, 0,          1, 2, 32'h108, 32'h2002, 3);
    tbl[20] = mkv(0, 0, 32'h0,   0, 0, 0,          0, 2, 32'h108, 32'h2002, 3);

    do_reset();
    chk("rst_commit", 96'(commit), 96'(0));
    chk("rst_halt",   96'(halt),   96'(0));
    chk("rst_err",    96'(wb_err), 96'(0));
    chk("rst_order",  96'(commit_order), 96'(0));
    chk("rst_pc",     96'(commit_pc), 96'(0));
    chk("rst_pkt",    96'(commit_pkt.rd_wdata), 96'(0));
    chk("rst_ready",  96'(alloc_ready), 96'(1));
    chk("rst_tag",    96'(alloc_tag), 96'(0));

    for (int r = 0; r < 21; r++) begin
      rst         = tbl[r].rst;
      alloc_valid = tbl[r].av;
      alloc_pc    = tbl[r].apc;
      alloc_inst  = inst_of(tbl[r].apc);
      set_wb({1'b0, tbl[r].wv}, tbl[r].t0, tbl[r].rd0, NOPC, 3'd0, 32'h0, NOPC);
      flush       = 1'b0;
      tick();
      chk($sformatf("vec%0d_commit", r), 96'(commit), 96'(tbl[r].e_commit));
      chk($sformatf("vec%0d_order", r),  96'(commit_order), 96'(tbl[r].e_order));
      chk($sformatf("vec%0d_pc", r),     96'(commit_pc), 96'(tbl[r].e_pc));
      chk($sformatf("vec%0d_inst", r),   96'(commit_inst), 96'(inst_of(tbl[r].e_pc)));
      chk($sformatf("vec%0d_rd", r),     96'(commit_pkt.rd_wdata), 96'(tbl[r].e_rd));
      chk($sformatf("vec%0d_tag", r),    96'(alloc_tag), 96'(tbl[r].e_tag));
      chk($sformatf("vec%0d_ready", r),  96'(alloc_ready), 96'(tbl[r].e_ready));
      chk($sformatf("vec%0d_err", r),    96'(wb_err), 96'(tbl[r].e_err));
    end
    idle_in();

    // Full / wrap: fill 8, hold a 9th, retire one, then the 9th gets tag 0 and order 8
    do_reset();
    mon_en = 1'b1;
    for (int i = 0; i < 9; i++) exp_q.push_back({64'(i), 32'h200 + 32'(4 * i)});
    for (int i = 0; i < 8; i++) begin
      do_alloc(32'h200 + 32'(4 * i));
      if (i == 6) chk("full_ready_7", 96'(alloc_ready), 96'(1));
    end
    chk("full_ready_8", 96'(alloc_ready), 96'(0));
    chk("full_tag_wrap", 96'(alloc_tag), 96'(0));
    alloc_valid = 1'b1;
    alloc_pc    = 32'h220;
    alloc_inst  = inst_of(32'h220);
    tick();
    chk("full_hold_tag", 96'(alloc_tag), 96'(0));
    chk("full_hold_ready", 96'(alloc_ready), 96'(0));
    set_wb(2'b01, 3'd0, 32'h3000, NOPC, 3'd0, 32'h0, NOPC);
    tick();
    set_wb(2'b00, 3'd0, 32'h0, NOPC, 3'd0, 32'h0, NOPC);
    chk("full_wb_tag", 96'(alloc_tag), 96'(0));
    tick();
    chk("full_refuse_tag", 96'(alloc_tag), 96'(0));
    chk("full_refuse_ready", 96'(alloc_ready), 96'(1));
    tick();
    chk("wrap_new_tag", 96'(alloc_tag), 96'(1));
    chk("wrap_ready", 96'(alloc_ready), 96'(0));
    alloc_valid = 1'b0;
    for (int p = 0; p < 4; p++) begin
      set_wb(2'b11, 3'(2 * p + 1), 32'h3001, NOPC, 3'(2 * p + 2), 32'h3002, NOPC);
      tick();
    end
    set_wb(2'b00, 3'd0, 32'h0, NOPC, 3'd0, 32'h0, NOPC);
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) tick();
    chk("full_drain", 96'(exp_q.size()), 96'(0));
    mon_en = 1'b0;
    exp_q.delete();

    // Dual wb collision and write to an unallocated tag
    do_reset();
    for (int i = 0; i < 4; i++) do_alloc(32'h300 + 32'(4 * i));
    chk("coll_err_before", 96'(wb_err), 96'(0));
    set_wb(2'b11, 3'd3, 32'hAAAA, NOPC, 3'd3, 32'hBBBB, NOPC);
    tick();
    chk("coll_err", 96'(wb_err), 96'(1));
    set_wb(2'b01, 3'd5, 32'hCCCC, NOPC, 3'd0, 32'h0, NOPC);
    tick();
    chk("coll_err_sticky", 96'(wb_err), 96'(1));
    chk("coll_no_commit", 96'(commit), 96'(0));
    set_wb(2'b11, 3'd0, 32'h10, NOPC, 3'd1, 32'h11, NOPC);
    tick();
    set_wb(2'b01, 3'd2, 32'h12, NOPC, 3'd0, 32'h0, NOPC);
    tick();
    set_wb(2'b00, 3'd0, 32'h0, NOPC, 3'd0, 32'h0, NOPC);
    wait_commit(32'h30C, 8, "coll_tag3_commit");
    chk("coll_ch0_kept", 96'(commit_pkt.rd_wdata), 96'(32'hAAAA));
    do_alloc(32'h310);
    do_alloc(32'h314);
    set_wb(2'b01, 3'd4, 32'h14, NOPC, 3'd0, 32'h0, NOPC);
    tick();
    set_wb(2'b00, 3'd0, 32'h0, NOPC, 3'd0, 32'h0, NOPC);
    wait_commit(32'h310, 4, "coll_tag4_commit");
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("coll_tag5_idle", 96'(commit), 96'(0));
    end

    // Halt: pc_wdata equal to pc stops retirement
    do_reset();
    do_alloc(32'h80);
    do_alloc(32'h84);
    set_wb(2'b11, 3'd0, 32'h1, 32'h80, 3'd1, 32'h2, 32'h88);
    tick();
    set_wb(2'b00, 3'd0, 32'h0, NOPC, 3'd0, 32'h0, NOPC);
    tick();
    chk("halt_commit", 96'(commit), 96'(1));
    chk("halt_flag", 96'(halt), 96'(1));
    chk("halt_pc", 96'(commit_pc), 96'(32'h80));
    tick();
    chk("halt_next_commit", 96'(commit), 96'(0));
    chk("halt_sticky", 96'(halt), 96'(1));
    do_alloc(32'h88);
    chk("halt_alloc_tag", 96'(alloc_tag), 96'(3));
    tick();
    chk("halt_later_commit", 96'(commit), 96'(0));

    // Flush: head retires on the flush edge, the rest is squashed
    do_reset();
    do_alloc(32'h3F0);
    set_wb(2'b01, 3'd0, 32'h50, NOPC, 3'd0, 32'h0, NOPC);
    tick();
    set_wb(2'b00, 3'd0, 32'h0, NOPC, 3'd0, 32'h0, NOPC);
    tick();
    for (int i = 0; i < 5; i++) do_alloc(32'h400 + 32'(4 * i));
    set_wb(2'b01, 3'd1, 32'h51, NOPC, 3'd0, 32'h0, NOPC);
    tick();
    set_wb(2'b10, 3'd0, 32'h0, NOPC, 3'd7, 32'h77, NOPC);
    flush       = 1'b1;
    alloc_valid = 1'b1;
    alloc_pc    = 32'h500;
    alloc_inst  = inst_of(32'h500);
    tick();
    idle_in();
    chk("flush_commit", 96'(commit), 96'(1));
    chk("flush_pc", 96'(commit_pc), 96'(32'h400));
    chk("flush_order", 96'(commit_order), 96'(1));
    chk("flush_tag", 96'(alloc_tag), 96'(2));
    chk("flush_ready", 96'(alloc_ready), 96'(1));
    chk("flush_no_err", 96'(wb_err), 96'(0));
    tick();
    chk("flush_after_commit", 96'(commit), 96'(0));
    for (int i = 0; i < 8; i++) begin
      do_alloc(32'h600 + 32'(4 * i));
      if (i == 6) chk("flush_cnt_7", 96'(alloc_ready), 96'(1));
    end
    chk("flush_cnt_8", 96'(alloc_ready), 96'(0));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2_order", 96'(commit_order), 96'(0));
    chk("rst2_ready", 96'(alloc_ready), 96'(1));
    chk("rst2_tag", 96'(alloc_tag), 96'(0));
    chk("rst2_commit", 96'(commit), 96'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
